// File: rtl/ov7725_dvp_tx_if.sv
`default_nettype none
// ============================================================================
//  Module   : ov7725_dvp_tx_if
//  Brief    : DVP camera bus plus generator control, between sensor emulator
//             (master) and capture/control side (slave).
//  Revision : 1.0 - initial release
// ============================================================================
interface ov7725_dvp_tx_if;
  logic        en;
  logic [1:0]  pat_sel;
  logic [15:0] cfg_color;
  logic        cam_vsync;
  logic        cam_href;
  logic [7:0]  cam_data;
  logic        frame_start;
  logic [15:0] frame_cnt;

  modport master (
    input  en, pat_sel, cfg_color,
    output cam_vsync, cam_href, cam_data, frame_start, frame_cnt
  );

  modport slave (
    output en, pat_sel, cfg_color,
    input  cam_vsync, cam_href, cam_data, frame_start, frame_cnt
  );
endinterface
`default_nettype wire

// File: rtl/ov7725_dvp_tx.sv
`default_nettype none
// ============================================================================
//  Module   : ov7725_dvp_tx
//  Brief    : OV7725-style DVP sensor emulator, RGB565 high byte first,
//             run-time selectable test patterns latched per frame.
//  Revision : 1.0 - initial release
// ============================================================================
module ov7725_dvp_tx #(
  parameter int H_ACT   = 640,
  parameter int H_BLANK = 144,
  parameter int V_SYNC  = 3,
  parameter int V_BP    = 17,
  parameter int V_ACT   = 480,
  parameter int V_FP    = 10
) (
  input  wire logic       cam_pclk,
  input  wire logic       rst_n,
  ov7725_dvp_tx_if.master bus
);
  localparam int LINE_LEN = 2*H_ACT + H_BLANK;
  localparam int V_TOTAL  = V_SYNC + V_BP + V_ACT + V_FP;
  localparam int BAR_W    = H_ACT/8;
  localparam int HW       = $clog2(LINE_LEN);
  localparam int VW       = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
  localparam int BW       = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  localparam logic [HW-1:0] c_H_LAST   = HW'(LINE_LEN - 1);
  localparam logic [HW-1:0] c_H_ACT2   = HW'(2*H_ACT);
  localparam logic [VW-1:0] c_V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] c_V_SYNC   = VW'(V_SYNC);
  localparam logic [VW-1:0] c_V_ACT0   = VW'(V_SYNC + V_BP);
  localparam logic [VW-1:0] c_V_ACT1   = VW'(V_SYNC + V_BP + V_ACT - 1);
  localparam logic [BW-1:0] c_BAR_LAST = BW'(BAR_W - 1);

  localparam logic [0:0] c_IDLE = 1'b0;
  localparam logic [0:0] c_RUN  = 1'b1;

  logic [0:0]    r_state;
  logic [0:0]    w_state_nxt;
  logic [HW-1:0] r_h_cnt;
  logic [VW-1:0] r_v_cnt;
  logic [BW-1:0] r_bar_cnt;
  logic [2:0]    r_bar_idx;
  logic [1:0]    r_pat_q;
  logic [15:0]   r_color_q;
  logic          r_vsync;
  logic          r_href;
  logic [7:0]    r_data;
  logic          r_frame_start;
  logic [15:0]   r_frame_cnt;

  logic          w_run;
  logic          w_boundary;
  logic          w_h_last;
  logic          w_frame_last;
  logic          w_v_act;
  logic          w_href_nxt;
  logic [15:0]   w_x;
  logic [15:0]   w_y;
  logic [15:0]   w_bar_color;
  logic [15:0]   w_pixel;

  assign w_h_last     = (r_h_cnt == c_H_LAST);
  assign w_frame_last = w_h_last && (r_v_cnt == c_V_LAST);

  always_ff @(posedge cam_pclk or negedge rst_n) begin
    if (!rst_n) r_state <= c_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Leaving RUN is only allowed on the last cycle of a frame.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:  if (bus.en) w_state_nxt = c_RUN;
      c_RUN:   if (w_frame_last && !bus.en) w_state_nxt = c_IDLE;
      default: w_state_nxt = c_IDLE;
    endcase
  end

  always_comb begin
    w_run      = (r_state == c_RUN);
    w_boundary = w_run && (r_h_cnt == '0) && (r_v_cnt == '0);
  end

  always_ff @(posedge cam_pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (!w_run || w_h_last) begin
      r_h_cnt <= '0;
      if (!w_run || r_v_cnt == c_V_LAST) r_v_cnt <= '0;
      else                               r_v_cnt <= r_v_cnt + 1'b1;
    end else begin
      r_h_cnt <= r_h_cnt + 1'b1;
    end
  end

  // Bar tracker follows x so the bar index never needs a divide.
  always_ff @(posedge cam_pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_bar_cnt <= '0;
      r_bar_idx <= '0;
    end else if (!w_run || w_h_last) begin
      r_bar_cnt <= '0;
      r_bar_idx <= '0;
    end else if (r_h_cnt[0] && (r_h_cnt < c_H_ACT2)) begin
      if (r_bar_cnt == c_BAR_LAST) begin
        r_bar_cnt <= '0;
        r_bar_idx <= r_bar_idx + 1'b1;
      end else begin
        r_bar_cnt <= r_bar_cnt + 1'b1;
      end
    end
  end

  assign w_x        = 16'(r_h_cnt >> 1);
  assign w_y        = 16'(r_v_cnt) - 16'(c_V_ACT0);
  assign w_v_act    = (r_v_cnt >= c_V_ACT0) && (r_v_cnt <= c_V_ACT1);
  assign w_href_nxt = w_run && w_v_act && (r_h_cnt < c_H_ACT2);

  always_comb begin
    w_bar_color = 16'h0000;
    case (r_bar_idx)
      3'd0:    w_bar_color = 16'hFFFF;
      3'd1:    w_bar_color = 16'hFFE0;
      3'd2:    w_bar_color = 16'h07FF;
      3'd3:    w_bar_color = 16'h07E0;
      3'd4:    w_bar_color = 16'hF81F;
      3'd5:    w_bar_color = 16'hF800;
      3'd6:    w_bar_color = 16'h001F;
      default: w_bar_color = 16'h0000;
    endcase
  end

  always_comb begin
    w_pixel = 16'h0000;
    case (r_pat_q)
      2'd0:    w_pixel = w_bar_color;
      2'd1:    w_pixel = w_x + w_y + r_frame_cnt;
      2'd2:    w_pixel = r_color_q;
      default: w_pixel = (w_x[3] ^ w_y[3]) ? 16'hFFFF : 16'h0000;
    endcase
  end

  always_ff @(posedge cam_pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_vsync       <= 1'b0;
      r_href        <= 1'b0;
      r_data        <= 8'h00;
      r_frame_start <= 1'b0;
      r_frame_cnt   <= 16'h0000;
      r_pat_q       <= 2'd0;
      r_color_q     <= 16'h0000;
    end else begin
      r_vsync       <= w_run && (r_v_cnt < c_V_SYNC);
      r_href        <= w_href_nxt;
      r_data        <= w_href_nxt ? (r_h_cnt[0] ? w_pixel[7:0] : w_pixel[15:8]) : 8'h00;
      r_frame_start <= w_boundary;
      if (w_boundary) begin
        r_frame_cnt <= r_frame_cnt + 1'b1;
        r_pat_q     <= bus.pat_sel;
        r_color_q   <= bus.cfg_color;
      end
    end
  end

  assign bus.cam_vsync   = r_vsync;
  assign bus.cam_href    = r_href;
  assign bus.cam_data    = r_data;
  assign bus.frame_start = r_frame_start;
  assign bus.frame_cnt   = r_frame_cnt;
endmodule
`default_nettype wire

// File: tb/tb_ov7725_dvp_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ov7725_dvp_tx
//  Brief    : Self-checking bench for ov7725_dvp_tx (8- and 16-pixel lines).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ov7725_dvp_tx;
  localparam int HB = 4, VS = 1, VBP = 1, VA = 2, VFP = 1;
  localparam int VT = VS + VBP + VA + VFP;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en;
  logic [1:0]  pat_sel;
  logic [15:0] cfg_color;
  int          checks = 0;
  int          errors = 0;
  bit          chk_on = 0;

  always #5 clk = ~clk;

  ov7725_dvp_tx_if if8 ();
  ov7725_dvp_tx_if if16 ();
  assign if8.en = en;         assign if16.en = en;
  assign if8.pat_sel = pat_sel;   assign if16.pat_sel = pat_sel;
  assign if8.cfg_color = cfg_color; assign if16.cfg_color = cfg_color;

  ov7725_dvp_tx #(.H_ACT(8), .H_BLANK(HB), .V_SYNC(VS), .V_BP(VBP), .V_ACT(VA), .V_FP(VFP))
    u_dut8 (.cam_pclk(clk), .rst_n(rst_n), .bus(if8));
  ov7725_dvp_tx #(.H_ACT(16), .H_BLANK(HB), .V_SYNC(VS), .V_BP(VBP), .V_ACT(VA), .V_FP(VFP))
    u_dut16 (.cam_pclk(clk), .rst_n(rst_n), .bus(if16));

  typedef struct packed {
    logic        run;
    int          pos;
    logic [15:0] fcnt;
    logic [1:0]  pat;
    logic [15:0] col;
    logic        vs;
    logic        hr;
    logic        fs;
    logic [7:0]  data;
  } mstate_t;

  mstate_t m8, m16;

  function automatic logic [15:0] ref_pixel(logic [1:0] pat, logic [15:0] col, int x, int y,
                                            logic [15:0] fcnt, int hact);
    logic [15:0] bars [8];
    bars = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
    case (pat)
      2'd0:    return bars[x / (hact / 8)];
      2'd1:    return 16'(x + y + int'(fcnt));
      2'd2:    return col;
      default: return (((x / 8) % 2) != ((y / 8) % 2)) ? 16'hFFFF : 16'h0000;
    endcase
  endfunction

  // One clock of the reference: outputs come from the frame position held before the edge.
  function automatic mstate_t model_step(mstate_t s, logic e, logic [1:0] ps, logic [15:0] cc, int hact);
    mstate_t n;
    int ll, frame, line, col, x, y;
    logic [15:0] pix;
    n = s;
    ll = 2*hact + HB;
    frame = ll * VT;
    n.vs = 1'b0; n.hr = 1'b0; n.fs = 1'b0; n.data = 8'h00;
    if (s.run) begin
      line = s.pos / ll;
      col  = s.pos % ll;
      if (s.pos == 0) begin
        n.fcnt = s.fcnt + 16'd1; n.pat = ps; n.col = cc; n.fs = 1'b1;
      end
      n.vs = (line < VS);
      if (line >= VS + VBP && line < VS + VBP + VA && col < 2*hact) begin
        x = col / 2;
        y = line - (VS + VBP);
        pix = ref_pixel(n.pat, n.col, x, y, s.fcnt, hact);
        n.hr = 1'b1;
        n.data = (col % 2 == 0) ? pix[15:8] : pix[7:0];
      end
      if (s.pos == frame - 1) begin n.pos = 0; n.run = e; end
      else n.pos = s.pos + 1;
    end else if (e) begin
      n.run = 1'b1; n.pos = 0;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m8  <= '0;
      m16 <= '0;
    end else begin
      m8  <= model_step(m8, en, pat_sel, cfg_color, 8);
      m16 <= model_step(m16, en, pat_sel, cfg_color, 16);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [26:0] outs8();
    return {if8.cam_vsync, if8.cam_href, if8.cam_data, if8.frame_start, if8.frame_cnt};
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      chk("model8", outs8(), {m8.vs, m8.hr, m8.data, m8.fs, m8.fcnt});
      chk("model16", {if16.cam_vsync, if16.cam_href, if16.cam_data, if16.frame_start, if16.frame_cnt},
          {m16.vs, m16.hr, m16.data, m16.fs, m16.fcnt});
    end
  end

  task automatic skip(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_fs8();
    int n = 0;
    do begin @(negedge clk); n++; end while (!if8.frame_start && n < 400);
    chk("wait_fs8", if8.frame_start, 1);
  endtask

  task automatic wait_fs16();
    int n = 0;
    do begin @(negedge clk); n++; end while (!if16.frame_start && n < 400);
    chk("wait_fs16", if16.frame_start, 1);
  endtask

  typedef struct packed {
    logic [1:0]   pat;
    logic [15:0]  color;
    logic [127:0] line;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int vs_n, hr_n, rise1, rise2, data_bad, fs_extra, idle_bad;
    logic prev;
    logic [7:0] exp_b;
    logic [15:0] fc_hold;
    logic [127:0] ln;

    vecs[0] = '{pat: 2'd0, color: 16'h0000, line: 128'hFFFF_FFE0_07FF_07E0_F81F_F800_001F_0000};
    vecs[1] = '{pat: 2'd2, color: 16'h1234, line: {8{16'h1234}}};
    vecs[2] = '{pat: 2'd3, color: 16'hBEEF, line: 128'h0};
    vecs[3] = '{pat: 2'd2, color: 16'hA55A, line: {8{16'hA55A}}};

    en = 1'b0; pat_sel = 2'd0; cfg_color = 16'h0000;
    #1 rst_n = 1'b0;
    skip(3);
    chk_on = 1;
    chk("reset_outputs", outs8(), 27'd0);
    rst_n = 1'b1;
    skip(50);
    chk("idle_outputs", outs8(), 27'd0);

    // Timing frame with solid A55A
    pat_sel = 2'd2; cfg_color = 16'hA55A; en = 1'b1;
    @(negedge clk);
    chk("fs_not_yet", if8.frame_start, 0);
    @(negedge clk);
    chk("fs_first", if8.frame_start, 1);
    chk("fcnt_first", if8.frame_cnt, 1);
    vs_n = 0; hr_n = 0; rise1 = -1; rise2 = -1; data_bad = 0; fs_extra = 0; prev = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (if8.cam_vsync) vs_n++;
      if (k > 0 && if8.frame_start) fs_extra++;
      if (if8.cam_href) begin
        hr_n++;
        if (!prev) begin
          if (rise1 < 0) rise1 = k; else rise2 = k;
        end
      end
      exp_b = if8.cam_href ? (((hr_n - 1) % 2 == 0) ? 8'hA5 : 8'h5A) : 8'h00;
      if (if8.cam_data !== exp_b) data_bad++;
      prev = if8.cam_href;
      @(negedge clk);
    end
    chk("vsync_len", vs_n, 20);
    chk("href_len", hr_n, 32);
    chk("href_rise1", rise1, 40);
    chk("href_rise2", rise2, 60);
    chk("timing_data", data_bad, 0);
    chk("fs_extra", fs_extra, 0);
    chk("fs_period", if8.frame_start, 1);
    chk("fcnt_second", if8.frame_cnt, 2);

    // Table of per-pattern row-0 byte streams
    for (int i = 0; i < 4; i++) begin
      pat_sel = vecs[i].pat; cfg_color = vecs[i].color;
      wait_fs8();
      skip(40);
      ln = vecs[i].line;
      for (int j = 0; j < 16; j++) begin
        chk($sformatf("vec%0d_byte%0d", i, j), if8.cam_data, ln[127-8*j -: 8]);
        @(negedge clk);
      end
    end

    // Pattern change mid-frame takes effect next frame (now at position 56)
    pat_sel = 2'd0;
    skip(4);
    chk("midpat_hi", if8.cam_data, 8'hA5);
    @(negedge clk);
    chk("midpat_lo", if8.cam_data, 8'h5A);
    wait_fs8();
    skip(42);
    chk("newpat_b2", if8.cam_data, 8'hFF);
    @(negedge clk);
    chk("newpat_b3", if8.cam_data, 8'hE0);

    // en dropped mid-frame: frame completes then idles
    en = 1'b0;
    skip(17);
    chk("enoff_href", if8.cam_href, 1);
    fc_hold = if8.frame_cnt;
    skip(40);
    chk("enoff_no_fs", if8.frame_start, 0);
    idle_bad = 0;
    for (int k = 0; k < 50; k++) begin
      if ({if8.cam_vsync, if8.cam_href, if8.cam_data, if8.frame_start} !== 11'd0) idle_bad++;
      if (if8.frame_cnt !== fc_hold) idle_bad++;
      @(negedge clk);
    end
    chk("enoff_idle", idle_bad, 0);
    en = 1'b1;
    @(negedge clk);
    chk("restart_wait", if8.frame_start, 0);
    @(negedge clk);
    chk("restart_vsync", if8.cam_vsync, 1);
    chk("restart_fcnt", if8.frame_cnt, fc_hold + 16'd1);

    // Async reset at cycle 37 of a frame
    skip(37);
    #2 rst_n = 1'b0;
    #1 chk("async_rst", outs8(), 27'd0);
    @(negedge clk);
    pat_sel = 2'd1;
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_fs_wait", if8.frame_start, 0);
    @(negedge clk);
    chk("rst_fs", if8.frame_start, 1);
    chk("rst_fcnt", if8.frame_cnt, 1);

    // Ramp on frame 5
    for (int t = 0; t < 6 && if8.frame_cnt != 16'd5; t++) wait_fs8();
    chk("ramp_frame", if8.frame_cnt, 5);
    skip(60);
    chk("ramp_hi", if8.cam_data, 8'h00);
    @(negedge clk);
    chk("ramp_lo", if8.cam_data, 8'h06);

    // Checker on 16-pixel lines
    pat_sel = 2'd3;
    wait_fs16();
    wait_fs16();
    skip(72);
    for (int j = 0; j < 32; j++) begin
      chk($sformatf("chk16_byte%0d", j), if16.cam_data, (j < 16) ? 8'h00 : 8'hFF);
      @(negedge clk);
    end

    // Randomised run against the reference model
    for (int c = 0; c < 4000; c++) begin
      if (c % 150 == 0) en = ($urandom_range(0, 3) != 0);
      pat_sel = 2'($urandom_range(0, 3));
      cfg_color = 16'($urandom);
      if ($urandom_range(0, 599) == 0) begin
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/ov7725_dvp_tx.md
Name: ov7725_dvp_tx

Overview:
- Synthesizable OV7725-style DVP transmitter / sensor emulator: generates cam_vsync, cam_href and 8-bit cam_data, with RGB565 sent high byte first, two bytes per pixel.
- Use 1: drives the camera-capture path on the board or in simulation without a physical sensor.
- Use 2: test-pattern source for bring-up of the HDMI/Sobel pipeline.
- Timing is parameterised; the pattern is selectable at run time.

Parameters:
- H_ACT, 640: active pixels per line; must be a multiple of 8.
- H_BLANK, 144: pclk cycles of horizontal blanking per line (href low); must be ≥1.
- V_SYNC, 3: lines with vsync high at frame start; must be ≥1.
- V_BP, 17: blank lines after vsync, before the first active line.
- V_ACT, 480: active lines per frame.
- V_FP, 10: blank lines after the last active line.
- Derived localparams:
  - LINE_LEN = 2*H_ACT + H_BLANK
  - V_TOTAL = V_SYNC + V_BP + V_ACT + V_FP
  - BAR_W = H_ACT/8

Ports:
- cam_pclk, in, 1: pixel clock; all logic on rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- en, in, 1: generator enable.
- pat_sel, in, 2: pattern select.
- cfg_color, in, 16: RGB565 value for the solid-colour pattern.
- cam_vsync, out, 1: frame sync, active high.
- cam_href, out, 1: line valid, active high.
- cam_data, out, 8: pixel byte.
- frame_start, out, 1: one-cycle pulse at the start of each frame.
- frame_cnt, out, 16: frames started since reset; wraps at 65535 → 0.

Behaviour:
- Reset is asynchronous: all outputs and counters go to 0 immediately, including during a frame. No partial frame resumes after release.
- Counters:
  - h_cnt runs 0..LINE_LEN-1.
  - v_cnt runs 0..V_TOTAL-1 and advances when h_cnt wraps.
  - Both wrap to 0 together at the end of the frame.
- Run state, two states:
  - IDLE: counters held at 0; cam_vsync/cam_href/cam_data/frame_start held at 0.
  - IDLE→RUN: when en=1, sampled each cycle.
  - RUN→IDLE: only at a frame boundary (h_cnt=LINE_LEN-1, v_cnt=V_TOTAL-1) with en=0. Deasserting en mid-frame completes the current frame.
- Frame boundary latching:
  - The cycle with counters at (0,0) in RUN is the frame boundary. It fires on the first RUN cycle and on every wrap.
  - On it, pat_sel and cfg_color are latched into pat_q/color_q; they are stable for the whole frame, giving no tearing.
  - On it, frame_cnt increments.
- Outputs are registered, one cycle after the counter state that produces them:
  - cam_vsync = (v_cnt < V_SYNC).
  - cam_href = (v_cnt in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACT-1]) and (h_cnt < 2*H_ACT).
  - cam_data:
    - When href is active: pixel[15:8] if h_cnt[0]=0, pixel[7:0] if h_cnt[0]=1.
    - Otherwise 8'h00.
  - frame_start = 1 in the cycle cam_vsync first rises for a frame.
  - frame_cnt updates in the same cycle as frame_start.
- Pixel coordinates: x = h_cnt>>1 (0..H_ACT-1); y = v_cnt-(V_SYNC+V_BP) (0..V_ACT-1).
- Patterns (pat_q):
  - 0, colour bars: bar index = x/BAR_W, implemented with a bar counter and no divider. Bar values in order: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
  - 1, ramp: pixel = (x + y + frame_cnt) mod 2^16.
  - 2, solid: pixel = color_q.
  - 3, checker: pixel = FFFF if x[3]^y[3], else 0000.
- Byte order matches the capture side:
  - Every href-high period has an even byte count (2*H_ACT).
  - The first byte after href rises is a high byte.
- Frame length: LINE_LEN*V_TOTAL pclk cycles. Consecutive frames have no gaps.

Test Plan:
Small parameters for all tests: H_ACT=8, H_BLANK=4, V_SYNC=1, V_BP=1, V_ACT=2, V_FP=1, giving LINE_LEN=20 and 100 cycles per frame.
- Reset/idle: rst_n=0, then 1 with en=0 for 50 cycles → all outputs 0, frame_cnt=0.
- Timing: en=1, pat_sel=2, cfg_color=16'hA55A.
  - frame_start one cycle after en is sampled; vsync high 20 cycles.
  - href high 16 cycles on each of lines 2 and 3, with 4-cycle gaps.
  - Data A5,5A repeated ×8 per line; 00 elsewhere.
  - Next frame_start exactly 100 cycles later; frame_cnt 1→2.
- Colour bars: pat_sel=0 → line bytes FF,FF,FF,E0,07,FF,07,E0,F8,1F,F8,00,00,1F,00,00.
- Checker/ramp:
  - pat_sel=3 with H_ACT=16 → pixels 0–7 are 0000, 8–15 are FFFF on row 0.
  - pat_sel=1 on frame_cnt=5 → first pixel of row 1 is 0006.
- Mid-frame control:
  - pat_sel changed mid-frame → the current frame is unchanged and the change applies from the next frame.
  - en=0 mid-frame → the frame completes, then outputs stay 0; en=1 → restart with vsync.
- Async reset at cycle 37 of a frame → outputs 0 in the same cycle. After release with en=1, a fresh frame starts with frame_cnt=1.
